// File: rtl/l_transform.sv
// Kuznyechik linear layer L (or L^-1): 16 LFSR-style R steps over GF(2^8), one step per clock.
// Single block in flight; IDLE -> BUSY (16 steps) -> DONE (valid/ready handshake).
module l_transform #(
   parameter bit INVERSE = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_i,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   // Byte i holds the l() coefficient for a_i, aligned with the data byte order.
   localparam logic [127:0] COEFS = 128'h94_20_85_10_C2_C0_01_FB_01_C0_C2_10_85_20_94_01;

   state_t       state;
   logic [3:0]   cnt;
   logic [127:0] work;
   logic [127:0] step;
   logic [127:0] rot;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] lfun(input logic [127:0] v);
      logic [7:0] acc;
      acc = 8'h00;
      for (int i = 0; i < 16; i++)
         acc = acc ^ gf_mul(v[8*i +: 8], COEFS[8*i +: 8]);
      return acc;
   endfunction

   // Inverse step evaluates l over (a14..a0, a15), i.e. the block rotated left by one byte.
   always_comb begin
      rot  = {work[119:0], work[127:120]};
      step = {lfun(work), work[127:8]};
      if (INVERSE)
         step = {work[119:0], lfun(rot)};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         work      <= '0;
         data_o    <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  work     <= data_i;
                  cnt      <= 4'd0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               work <= step;
               cnt  <= cnt + 4'd1;
               if (cnt == 4'd15) begin
                  data_o    <= step;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l_transform.sv
// Self-checking bench for l_transform: forward and inverse instances, spec vectors,
// corner sequences and random blocks against a byte-array reference model.
module tb_l_transform;

   logic         clk;
   logic         rst;
   logic         in_valid  [2];
   logic         in_ready  [2];
   logic         out_valid [2];
   logic         out_ready [2];
   logic [127:0] data_i    [2];
   logic [127:0] data_o    [2];

   int checks = 0;
   int errors = 0;

   l_transform #(.INVERSE(1'b0)) u_fwd (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .data_i(data_i[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .data_o(data_o[0]));

   l_transform #(.INVERSE(1'b1)) u_inv (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .data_i(data_i[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .data_o(data_o[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // Reference: carry-less product then reduction by 0x1C3.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      for (int k = 15; k >= 8; k--)
         if (p[k]) p = p ^ (16'h1C3 << (k - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] model(input logic [127:0] x, input bit inv);
      logic [7:0] a [16];
      int c [16] = '{1, 148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148};
      logic [7:0] s;
      logic [127:0] y;
      for (int i = 0; i < 16; i++) a[i] = x[8*i +: 8];
      repeat (16) begin
         s = 8'h00;
         if (!inv) begin
            for (int i = 0; i < 16; i++) s = s ^ gmul(a[i], 8'(c[i]));
            for (int i = 0; i < 15; i++) a[i] = a[i+1];
            a[15] = s;
         end else begin
            for (int i = 1; i < 16; i++) s = s ^ gmul(a[i-1], 8'(c[i]));
            s = s ^ gmul(a[15], 8'(c[0]));
            for (int i = 15; i > 0; i--) a[i] = a[i-1];
            a[0] = s;
         end
      end
      for (int i = 0; i < 16; i++) y[8*i +: 8] = a[i];
      return y;
   endfunction

   // Offer one block, measure latency, check result and completion handshake.
   task automatic run_block(input int m, input logic [127:0] din, input logic [127:0] exp,
                            input string nm);
      int n;
      n = 0;
      while (!in_ready[m] && n < 50) begin @(negedge clk); n++; end
      chk({nm, "_ready"}, 128'(in_ready[m]), 128'd1);
      in_valid[m]  = 1'b1;
      data_i[m]    = din;
      out_ready[m] = 1'b1;
      @(negedge clk);
      in_valid[m] = 1'b0;
      data_i[m]   = {$urandom, $urandom, $urandom, $urandom};
      n = 0;
      while (!out_valid[m] && n < 40) begin @(negedge clk); n++; end
      chk({nm, "_latency"}, 128'(n), 128'd16);
      chk({nm, "_data"}, data_o[m], exp);
      @(negedge clk);
      chk({nm, "_ovalid_drop"}, 128'(out_valid[m]), 128'd0);
      chk({nm, "_iready_back"}, 128'(in_ready[m]), 128'd1);
      out_ready[m] = 1'b0;
   endtask

   typedef struct {
      int           m;
      logic [127:0] din;
      logic [127:0] exp;
      string        nm;
   } vec_t;

   vec_t tbl [4];

   initial begin
      logic [127:0] held;
      logic [127:0] din;
      int n;

      tbl[0] = '{0, 128'h64a59400000000000000000000000000, 128'hd456584dd0e3e84cc3166e4b7fa2890d, "fwd_vec"};
      tbl[1] = '{1, 128'hd456584dd0e3e84cc3166e4b7fa2890d, 128'h64a59400000000000000000000000000, "inv_vec"};
      tbl[2] = '{0, 128'h0, 128'h0, "fwd_zero"};
      tbl[3] = '{1, 128'h0, 128'h0, "inv_zero"};

      for (int m = 0; m < 2; m++) begin
         in_valid[m] = 1'b0; out_ready[m] = 1'b0; data_i[m] = '0;
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ovalid", 128'(out_valid[0]), 128'd0);
      chk("rst_data", data_o[0], 128'd0);
      chk("rst_data_inv", data_o[1], 128'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_iready", 128'(in_ready[0]), 128'd1);
      chk("rst_iready_inv", 128'(in_ready[1]), 128'd1);

      for (int k = 0; k < 4; k++)
         run_block(tbl[k].m, tbl[k].din, tbl[k].exp, tbl[k].nm);

      // Single-step probe on the forward working register.
      in_valid[0] = 1'b1;
      data_i[0]   = 128'h00000000000000000000000000000100;
      @(negedge clk);
      in_valid[0] = 1'b0;
      @(negedge clk);
      chk("step1", u_fwd.work, 128'h94000000000000000000000000000001);
      @(negedge clk);
      chk("step2", u_fwd.work, 128'ha5940000000000000000000000000000);
      n = 0;
      while (!out_valid[0] && n < 40) begin @(negedge clk); n++; end
      chk("step_done", data_o[0], model(128'h100, 1'b0));

      // Backpressure: hold DONE while offering other data.
      held = data_o[0];
      for (int i = 0; i < 10; i++) begin
         in_valid[0] = 1'b1;
         data_i[0]   = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         chk("bp_data", data_o[0], held);
         chk("bp_ovalid", 128'(out_valid[0]), 128'd1);
         chk("bp_iready", 128'(in_ready[0]), 128'd0);
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(negedge clk);
      out_ready[0] = 1'b0;
      chk("bp_release_ovalid", 128'(out_valid[0]), 128'd0);
      chk("bp_release_iready", 128'(in_ready[0]), 128'd1);
      repeat (20) @(negedge clk);
      chk("bp_no_second", 128'(out_valid[0]), 128'd0);

      // Reset partway through a transform.
      in_valid[0] = 1'b1;
      data_i[0]   = 128'h0123456789abcdef0011223344556677;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("midrst_ovalid", 128'(out_valid[0]), 128'd0);
      chk("midrst_data", data_o[0], 128'd0);
      chk("midrst_work", u_fwd.work, 128'd0);
      repeat (25) @(negedge clk);
      chk("midrst_no_partial", 128'(out_valid[0]), 128'd0);
      din = 128'hfedcba98765432100123456789abcdef;
      run_block(0, din, model(din, 1'b0), "midrst_fresh");

      // Back-to-back random blocks in both modes.
      for (int i = 0; i < 6; i++) begin
         for (int m = 0; m < 2; m++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            run_block(m, din, model(din, m[0]), m == 0 ? "rand_fwd" : "rand_inv");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/l_transform.md
L_TRANSFORM -- requirements
Module: l_transform

Interface
REQ-001 Parameter: INVERSE, default 0, 0 = forward L (encrypt path), 1 = inverse L^-1 (decrypt path).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  data_i is valid this cycle.
REQ-005 in_ready  output  1  block can accept a new block this cycle.
REQ-006 data_i  input  128  input block; byte a15 = data_i[127:120], a0 = data_i[7:0].
REQ-007 out_valid  output  1  data_o holds a finished result.
REQ-008 out_ready  input  1  consumer accepts data_o this cycle.
REQ-009 data_o  output  128  transformed block, same byte ordering as data_i.

Function
REQ-010 Arithmetic in GF(2^8) with reduction polynomial x^8+x^7+x^6+x+1 (0x1C3); addition is XOR.
REQ-011 l(a15..a0) = 148a15 + 32a14 + 133a13 + 16a12 + 194a11 + 192a10 + 1a9 + 251a8 + 1a7 + 192a6 + 194a5 + 16a4 + 133a3 + 32a2 + 148a1 + 1a0.
REQ-012 INVERSE=0: one step R(a) = l(a15..a0) || a15..a1, so the new byte becomes the MSB and the block shifts right by 8 bits.
REQ-013 INVERSE=1: one step R^-1(a) = a14..a0 || l(a14..a0, a15), so the new byte becomes the LSB and the block shifts left by 8 bits.
REQ-014 Exactly one R (or R^-1) step per clock; the full transform is 16 steps.
REQ-015 FSM states: IDLE, BUSY, DONE.
REQ-016 IDLE: in_ready=1, out_valid=0; when in_valid=1, latch data_i into the working register, clear the 4-bit step counter, and go to BUSY.
REQ-017 BUSY: in_ready=0, out_valid=0; each cycle apply one step and increment the counter; after the step taken with counter=15, go to DONE. The counter wraps 15->0 and never exceeds 15.
REQ-018 DONE: out_valid=1, in_ready=0, data_o = working register; when out_ready=1, go to IDLE.
REQ-019 Latency: transfer at edge T gives out_valid=1 after edge T+16; at most one block in flight, so throughput is 1 block per 17 cycles or worse.
REQ-020 While out_valid=1 and out_ready=0, data_o and out_valid hold stable indefinitely.
REQ-021 in_valid outside IDLE is ignored; data_i is not sampled.
REQ-022 out_ready outside DONE is ignored.
REQ-023 data_o is registered and is not combinationally dependent on any input.
REQ-024 The block asserts in_ready in the cycle after the DONE handshake; it does not accept new input in the same cycle it delivers output.

Reset
REQ-025 rst=0 at a clock edge forces state=IDLE, counter=0, working register=0, out_valid=0, data_o=0; in_ready=1 after the first edge with rst=1.
REQ-026 rst=0 during BUSY or DONE aborts the transform; the partial result is never presented.
REQ-027 rst has priority over every handshake in the same cycle.

Verification
REQ-028 INVERSE=0, data_i=64a59400000000000000000000000000, out_ready=1 -> out_valid exactly 16 cycles after acceptance, data_o=d456584dd0e3e84cc3166e4b7fa2890d.
REQ-029 INVERSE=1, data_i=d456584dd0e3e84cc3166e4b7fa2890d -> data_o=64a59400000000000000000000000000 after 16 cycles.
REQ-030 Single-step check with an internal probe after the first BUSY cycle, INVERSE=0: 00000000000000000000000000000100 -> working register 94000000000000000000000000000001; next step -> a5940000000000000000000000000000.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with other data -> data_o unchanged, in_ready=0, no second acceptance; raise out_ready -> handshake, then in_ready=1 next cycle.
REQ-032 Reset mid-operation: rst=0 at step 8 -> next cycle out_valid=0, data_o=0, state IDLE; a fresh block then completes with correct result and full 16-cycle latency.
REQ-033 All-zero input -> all-zero output in both modes; back-to-back random blocks checked against a reference model of REQ-010..REQ-013.
